// File: rtl/multi_pp_accum.sv
// multi_pp_accum: combines four 8-bit partial products of an 8x8
// unsigned multiply into a 16-bit product, one partial product per cycle.
// Ports: clk, clr_n (async active-low reset), start, pp0..pp3 (partial
// products, weights 2^0, 2^4, 2^4, 2^8) -> busy, done (1-cycle pulse),
// product (16-bit result, held between results).
// Optional macro MULTI_PP_ACCUM_OUT_REG_EN adds one output register stage.
module multi_pp_accum (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        start,
   input  logic [7:0]  pp0,
   input  logic [7:0]  pp1,
   input  logic [7:0]  pp2,
   input  logic [7:0]  pp3,
   output logic        busy,
   output logic        done,
   output logic [15:0] product
);

   typedef enum logic [2:0] {
      IDLE,
      ACC1,
      ACC2,
      ACC3,
      DONE
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] acc;
   logic [15:0] acc_nxt;
   logic [7:0]  pp1_q;
   logic [7:0]  pp2_q;
   logic [7:0]  pp3_q;
   logic [15:0] prod_q;
   logic        done_q;
   logic        hold;
   logic        accept;

`ifdef MULTI_PP_ACCUM_OUT_REG_EN
   // Result still in the output stage: stay busy so a new start waits.
   assign hold = done_q;
`else
   assign hold = 1'b0;
`endif

   assign accept = (state == IDLE) && start && !hold;
   assign busy   = (state != IDLE) || hold;

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = ACC1;
               acc_nxt   = {8'h00, pp0};
            end
         end
         ACC1: begin
            state_nxt = ACC2;
            acc_nxt   = acc + {4'h0, pp1_q, 4'h0};
         end
         ACC2: begin
            state_nxt = ACC3;
            acc_nxt   = acc + {4'h0, pp2_q, 4'h0};
         end
         ACC3: begin
            state_nxt = DONE;
            acc_nxt   = acc + {pp3_q, 8'h00};
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state  <= IDLE;
         acc    <= 16'h0000;
         pp1_q  <= 8'h00;
         pp2_q  <= 8'h00;
         pp3_q  <= 8'h00;
         prod_q <= 16'h0000;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         acc    <= acc_nxt;
         done_q <= (state == DONE);
         if (accept) begin
            pp1_q <= pp1;
            pp2_q <= pp2;
            pp3_q <= pp3;
         end
         if (state == DONE) begin
            prod_q <= acc;
         end
      end
   end

`ifdef MULTI_PP_ACCUM_OUT_REG_EN
   logic [15:0] prod_o;
   logic        done_o;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         prod_o <= 16'h0000;
         done_o <= 1'b0;
      end else begin
         prod_o <= prod_q;
         done_o <= done_q;
      end
   end

   assign product = prod_o;
   assign done    = done_o;
`else
   assign product = prod_q;
   assign done    = done_q;
`endif

endmodule

// File: tb/tb_multi_pp_accum.sv
// tb_multi_pp_accum: scoreboard bench for multi_pp_accum.
// Expected products and done cycles are queued at start; a monitor checks.
module tb_multi_pp_accum;

`ifdef MULTI_PP_ACCUM_OUT_REG_EN
   localparam int LAT  = 5;
   localparam int BUSY = 5;
`else
   localparam int LAT  = 4;
   localparam int BUSY = 4;
`endif

   typedef struct {
      logic [15:0] p;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        clr_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  pp0 = 8'h00;
   logic [7:0]  pp1 = 8'h00;
   logic [7:0]  pp2 = 8'h00;
   logic [7:0]  pp3 = 8'h00;
   logic        busy;
   logic        done;
   logic [15:0] product;

   exp_t q[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   n_exp = 0;
   int   n_done = 0;

   multi_pp_accum dut (
      .clk     (clk),
      .clr_n   (clr_n),
      .start   (start),
      .pp0     (pp0),
      .pp1     (pp1),
      .pp2     (pp2),
      .pp3     (pp3),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued result.
   always @(negedge clk) begin
      if (done) begin
         exp_t e;
         n_done++;
         if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = q.pop_front();
            chk("product", int'(product), int'(e.p));
            chk("done_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic scramble();
      pp0 = 8'($urandom);
      pp1 = 8'($urandom);
      pp2 = 8'($urandom);
      pp3 = 8'($urandom);
   endtask

   // Raise start now; returns #1 after the accepting edge, start low.
   task automatic do_start(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d,
                           input logic [15:0] p);
      exp_t e;
      start = 1'b1;
      pp0 = a;
      pp1 = b;
      pp2 = c;
      pp3 = d;
      @(posedge clk);
      #1;
      e.p   = p;
      e.cyc = cyc + LAT;
      q.push_back(e);
      n_exp++;
      start = 1'b0;
      scramble();
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || done) && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 30) chk("idle_timeout", 1, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic busy_len();
      int n = 0;
      while (busy && n < 20) begin
         n++;
         @(posedge clk);
         #1;
      end
      chk("busy_cycles", n, BUSY);
   endtask

   initial begin
      // Reset state
      #1;
      chk("rst_product", int'(product), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_busy", int'(busy), 0);
      repeat (2) @(posedge clk);
      #1;
      clr_n = 1'b1;
      @(posedge clk);
      #1;

      // 0xFF*0xFF
      do_start(8'hE1, 8'hE1, 8'hE1, 8'hE1, 16'hFE01);
      wait_idle();

      // 0x12*0x34 and busy duration
      do_start(8'd8, 8'd4, 8'd6, 8'd3, 16'h03A8);
      busy_len();
      wait_idle();

      // all zero, then 1
      do_start(8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);
      wait_idle();
      do_start(8'h01, 8'h00, 8'h00, 8'h00, 16'h0001);
      wait_idle();

      // start while busy is ignored
      do_start(8'd8, 8'd4, 8'd6, 8'd3, 16'h03A8);
      start = 1'b1;
      pp0 = 8'hFF;
      pp1 = 8'hFF;
      pp2 = 8'hFF;
      pp3 = 8'hFF;
      @(posedge clk);
      #1;
      start = 1'b0;
      scramble();
      wait_idle();

      // reset during ACC2 abandons the operation
      do_start(8'hE1, 8'hE1, 8'hE1, 8'hE1, 16'hFE01);
      @(posedge clk);
      #2;
      clr_n = 1'b0;
      #1;
      chk("midrst_product", int'(product), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      void'(q.pop_back());
      n_exp--;
      @(posedge clk);
      #1;
      clr_n = 1'b1;
      @(posedge clk);
      #1;
      do_start(8'd8, 8'd4, 8'd6, 8'd3, 16'h03A8);
      wait_idle();

      // back-to-back: second start raised in the done cycle
      do_start(8'hE1, 8'hE1, 8'hE1, 8'hE1, 16'hFE01);
      begin
         int n = 0;
         while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
         end
         if (n >= 20) chk("b2b_timeout", 1, 0);
      end
`ifdef MULTI_PP_ACCUM_OUT_REG_EN
      chk("b2b_busy_low", int'(busy), 0);
`endif
      do_start(8'd8, 8'd4, 8'd6, 8'd3, 16'h03A8);
      wait_idle();

      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", q.size(), 0);
      chk("done_count", n_done, n_exp);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, got 1 expected 0");
      $fatal(1);
   end

endmodule

// File: doc/multi_pp_accum.md
MULTI_PP_ACCUM -- requirements
Module: multi_pp_accum

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 clr_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to combine the four partial products presented this cycle.
REQ-005 pp0  input  8  A[3:0]*B[3:0], weight 2^0.
REQ-006 pp1  input  8  A[7:4]*B[3:0], weight 2^4.
REQ-007 pp2  input  8  A[3:0]*B[7:4], weight 2^4.
REQ-008 pp3  input  8  A[7:4]*B[7:4], weight 2^8.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 done  output  1  single-cycle pulse marking a new product.
REQ-011 product  output  16  the full 8x8 unsigned product, held between results.

Function
REQ-012 The block SHALL implement FSM states IDLE, ACC1, ACC2, ACC3 and DONE.
REQ-013 In IDLE with start=1, the block SHALL do the following and move to ACC1:
- capture pp1..pp3 into internal registers;
- load the 16-bit accumulator with zero-extended pp0.
REQ-014 In IDLE with start=0, the block SHALL stay in IDLE with the accumulator unchanged.
REQ-015 In ACC1, the block SHALL add {4'b0, pp1_reg, 4'b0} to the accumulator and move to ACC2.
REQ-016 In ACC2, the block SHALL add {4'b0, pp2_reg, 4'b0} to the accumulator and move to ACC3.
REQ-017 In ACC3, the block SHALL add {pp3_reg, 8'b0} to the accumulator and move to DONE.
REQ-018 In DONE, the block SHALL register product <= accumulator, assert done for exactly one cycle, and return to IDLE.
REQ-019 All arithmetic SHALL be unsigned and 16 bits wide; no sum can exceed 0xFE01, so no overflow handling exists.
REQ-020 Latency: for start sampled at edge T, product SHALL update and done SHALL be high in the cycle after edge T+4.
REQ-021 start while busy=1 (including the DONE state) SHALL be ignored, with no effect on captured operands or result.
REQ-022 Back-to-back operation: start asserted in the cycle following done SHALL be accepted, giving a throughput of one result per 5 cycles.
REQ-023 pp0..pp3 SHALL be don't-care in every cycle except the cycle in which start is accepted.
REQ-024 product SHALL hold its last value until the next DONE state; done SHALL be low in all other states.

Reset
REQ-025 clr_n=0 SHALL immediately force the following, regardless of clock: state=IDLE, accumulator=0, pp registers=0, product=16'h0000, done=0, busy=0.
REQ-026 Reset asserted mid-operation SHALL abandon the operation with no done pulse; after release, the first start SHALL be accepted normally.
REQ-027 Reset release SHALL take effect at the first rising clk edge with clr_n=1.

Configuration
REQ-028 Macro MULTI_PP_ACCUM_OUT_REG_EN SHALL control an extra output register stage:
- defined: product and done pass through one additional register stage; latency becomes T+5; busy stays high through that extra cycle; throughput is one result per 6 cycles;
- undefined: behaviour is exactly as in REQ-020 and REQ-022.

Verification
REQ-029 Reset, then start with pp0..pp3=8'hE1 (0xFF*0xFF) -> product=16'hFE01 with done pulse 4 cycles later (5 with macro).
REQ-030 start with pp0=8, pp1=4, pp2=6, pp3=3 (0x12*0x34) -> product=16'h03A8; busy high for exactly 4 cycles (5 with macro).
REQ-031 All pp=0 -> product=16'h0000 with done pulse; then pp0=1, others 0 -> product=16'h0001.
REQ-032 Pulse start again, with pp0..pp3=8'hFF, in the cycle after the first start (while busy) -> ignored; the first result is delivered unchanged and exactly one done pulse occurs.
REQ-033 Pull clr_n low during ACC2 -> outputs read 0 immediately and no done pulse occurs; a fresh start after release yields the correct product.
REQ-034 Two starts, the second in the cycle after done (0xFF*0xFF, then 0x12*0x34) -> two done pulses 5 cycles apart, with products FE01 then 03A8.
